// File: rtl/lcd_write_sched_if.sv
// UART-to-LCD write scheduler bundle: received byte strobe in, LCD pins
// and status out.
interface lcd_write_sched_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          lcd_rs;
  logic          lcd_e;
  logic [7:0]    lcd_data;
  logic          init_done;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic [7:0]    drop_cnt;

  modport master (
    output rx_valid, rx_data,
    input  lcd_rs, lcd_e, lcd_data,
    input  init_done, busy, fifo_level, drop_cnt
  );

  modport slave (
    input  rx_valid, rx_data,
    output lcd_rs, lcd_e, lcd_data,
    output init_done, busy, fifo_level, drop_cnt
  );
endinterface

// File: rtl/lcd_write_sched.sv
// HD44780 write scheduler: rx FIFO, power-up init, timed E strobes, wrap/CR.
// Optional LCD_CLEAR_ON_FF_EN: byte 0x0C clears the display.
module lcd_write_sched #(
  parameter int E_HIGH_CYC = 50000,
  parameter int E_CYC      = 100000,
  parameter int CLR_CYC    = 200000,
  parameter int FIFO_DEPTH = 8,
  parameter int COLS       = 16
) (
  input logic clk,
  input logic rst,
  lcd_write_sched_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLR_CYC + 1);
  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DECODE,
    S_ADDR,
    S_DATA,
    S_CLR
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [LW-1:0] lvl_q;
  logic [7:0]    drop_q;

  state_t        state_q;
  logic [2:0]    idx_q;
  logic          run_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] len_q;
  logic          lcd_e_q;
  logic          lcd_rs_q;
  logic [7:0]    lcd_data_q;
  logic          done_q;
  logic          busy_q;
  logic [7:0]    byte_q;
  logic          row_q;
  logic [XW-1:0] col_q;
  logic          need_q;

  logic          pop;
  logic          push;
  logic          wr_end;
  logic [7:0]    addr_cmd;

  assign pop    = (state_q == S_IDLE) && (lvl_q != '0);
  assign push   = bus.rx_valid &&
                  ((lvl_q != LW'(FIFO_DEPTH)) || pop);
  assign wr_end = (cnt_q == len_q - 1'b1);
  assign addr_cmd = 8'h80 | (row_q ? 8'h40 : 8'h00) | 8'(col_q);

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h06;
      3'd3:    return 8'h01;
      default: return 8'h80;
    endcase
  endfunction

  // Starts a write: bus and rs settle with E rising in the same cycle.
  task automatic launch(input logic rs, input logic [7:0] d);
    lcd_rs_q   <= rs;
    lcd_data_q <= d;
    lcd_e_q    <= 1'b1;
    cnt_q      <= '0;
    len_q      <= (!rs && d == 8'h01) ? CW'(CLR_CYC) : CW'(E_CYC);
  endtask

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      lvl_q  <= '0;
      drop_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      if (push && !pop)      lvl_q <= lvl_q + 1'b1;
      else if (pop && !push) lvl_q <= lvl_q - 1'b1;
      if (bus.rx_valid && !push && drop_q != 8'hFF)
        drop_q <= drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_INIT;
      idx_q      <= '0;
      run_q      <= 1'b0;
      cnt_q      <= '0;
      len_q      <= CW'(E_CYC);
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      byte_q     <= '0;
      row_q      <= 1'b0;
      col_q      <= '0;
      need_q     <= 1'b0;
    end else begin
      busy_q <= (state_q != S_IDLE) || (lvl_q != '0);
      cnt_q  <= cnt_q + 1'b1;
      if (cnt_q == CW'(E_HIGH_CYC - 1)) lcd_e_q <= 1'b0;
      unique case (state_q)
        S_INIT: begin
          if (!run_q) begin
            run_q <= 1'b1;
            launch(1'b0, init_cmd(idx_q));
          end else if (wr_end) begin
            if (idx_q == 3'd4) begin
              done_q  <= 1'b1;
              row_q   <= 1'b0;
              col_q   <= '0;
              need_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              idx_q <= idx_q + 3'd1;
              launch(1'b0, init_cmd(idx_q + 3'd1));
            end
          end
        end
        S_IDLE: begin
          if (pop) begin
            byte_q  <= mem_q[rp_q];
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (byte_q == 8'h0D) begin
            col_q   <= '0;
            need_q  <= 1'b1;
            state_q <= S_IDLE;
          end
`ifdef LCD_CLEAR_ON_FF_EN
          else if (byte_q == 8'h0C) begin
            launch(1'b0, 8'h01);
            state_q <= S_CLR;
          end
`endif
          else if (need_q) begin
            launch(1'b0, addr_cmd);
            state_q <= S_ADDR;
          end else begin
            launch(1'b1, byte_q);
            state_q <= S_DATA;
          end
        end
        S_ADDR: begin
          if (wr_end) begin
            need_q <= 1'b0;
            launch(1'b1, byte_q);
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (wr_end) begin
            // Wrap to the other line; no scrolling.
            if (col_q == XW'(COLS - 1)) begin
              col_q  <= '0;
              row_q  <= ~row_q;
              need_q <= 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
            state_q <= S_IDLE;
          end
        end
        S_CLR: begin
          if (wr_end) begin
            row_q   <= 1'b0;
            col_q   <= '0;
            need_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.lcd_e      = lcd_e_q;
  assign bus.lcd_rs     = lcd_rs_q;
  assign bus.lcd_data   = lcd_data_q;
  assign bus.init_done  = done_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_level = lvl_q;
  assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_lcd_write_sched.sv
// Directed bench for lcd_write_sched with short timing parameters.
// Watches lcd_e at falling clock edges and logs every LCD write.
module tb_lcd_write_sched;
  logic clk;
  logic rst;

  lcd_write_sched_if #(.FIFO_DEPTH(4)) bus ();

  lcd_write_sched #(
    .E_HIGH_CYC(4),
    .E_CYC(8),
    .CLR_CYC(16),
    .FIFO_DEPTH(4),
    .COLS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         rise;
    int         hi;
  } wr_t;

  typedef struct {
    logic [7:0] din;
    int         nw;
    logic [8:0] w0;
    logic [8:0] w1;
  } vec_t;

  wr_t  wr [64];
  int   nw = 0;
  int   cyc = 0;
  logic prev_e = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   pc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.lcd_e === 1'b1 && !prev_e && nw < 64) begin
      wr[nw].rs   = bus.lcd_rs;
      wr[nw].d    = bus.lcd_data;
      wr[nw].rise = cyc;
      wr[nw].hi   = 0;
      nw++;
    end
    if (bus.lcd_e !== 1'b1 && prev_e && nw > 0)
      wr[nw-1].hi = cyc - wr[nw-1].rise;
    prev_e = (bus.lcd_e === 1'b1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    pc = cyc;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    repeat (3) @(negedge clk);
    while (bus.busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", int'(bus.busy), 0);
  endtask

  logic [7:0] init_exp [5];
  int         init_per [4];
  vec_t       tbl [7];

  initial begin
    int k;
    int base;
    int done_cyc;

    init_exp = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h80};
    init_per = '{8, 8, 8, 16};
    tbl[0] = '{8'h41, 2, {1'b0, 8'hC0}, {1'b1, 8'h41}};
    tbl[1] = '{8'h0D, 0, 9'h0, 9'h0};
    tbl[2] = '{8'h42, 2, {1'b0, 8'hC0}, {1'b1, 8'h42}};
    tbl[3] = '{8'h43, 1, {1'b1, 8'h43}, 9'h0};
    tbl[4] = '{8'h44, 1, {1'b1, 8'h44}, 9'h0};
    tbl[5] = '{8'h45, 1, {1'b1, 8'h45}, 9'h0};
    tbl[6] = '{8'h46, 2, {1'b0, 8'h80}, {1'b1, 8'h46}};

    rst = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_e",     int'(bus.lcd_e), 0);
    chk("rst_rs",    int'(bus.lcd_rs), 0);
    chk("rst_data",  int'(bus.lcd_data), 0);
    chk("rst_done",  int'(bus.init_done), 0);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_level", int'(bus.fifo_level), 0);
    chk("rst_drop",  int'(bus.drop_cnt), 0);

    // Release, and push six bytes while init is running.
    rst = 1'b1;
    k = 0;
    while (!bus.init_done && k < 300) begin
      @(negedge clk);
      if (k < 6) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h31 + 8'(k);
      end else begin
        bus.rx_valid = 1'b0;
      end
      k++;
    end
    bus.rx_valid = 1'b0;
    done_cyc = cyc;
    chk("init_done", int'(bus.init_done), 1);
    chk("init_len",  done_cyc - wr[0].rise, 48);
    chk("init_lvl",  int'(bus.fifo_level), 4);
    chk("init_drop", int'(bus.drop_cnt), 2);
    chk("init_busy", int'(bus.busy), 1);
    chk("init_nw",   nw, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("init_w%0d", i), int'({wr[i].rs, wr[i].d}),
          int'({1'b0, init_exp[i]}));
      chk($sformatf("init_hi%0d", i), wr[i].hi, 4);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("init_per%0d", i), wr[i+1].rise - wr[i].rise,
          init_per[i]);

    wait_idle();
    chk("q_nw", nw, 9);
    for (int i = 0; i < 4; i++)
      chk($sformatf("q_w%0d", i), int'({wr[5+i].rs, wr[5+i].d}),
          int'({1'b1, 8'h31 + 8'(i)}));
    chk("q_lat", wr[5].rise - done_cyc, 2);
    chk("q_gap", wr[6].rise - wr[5].rise, 10);
    chk("q_lvl", int'(bus.fifo_level), 0);

    for (int i = 0; i < 7; i++) begin
      base = nw;
      push(tbl[i].din);
      wait_idle();
      chk($sformatf("tbl%0d_nw", i), nw - base, tbl[i].nw);
      if (tbl[i].nw > 0)
        chk($sformatf("tbl%0d_w0", i),
            int'({wr[base].rs, wr[base].d}), int'(tbl[i].w0));
      if (tbl[i].nw > 1)
        chk($sformatf("tbl%0d_w1", i),
            int'({wr[base+1].rs, wr[base+1].d}), int'(tbl[i].w1));
    end

    base = nw;
    push(8'h48);
    wait_idle();
    chk("lat_nw",   nw - base, 1);
    chk("lat_cyc",  wr[base].rise - pc, 3);
    chk("lat_w",    int'({wr[base].rs, wr[base].d}), int'({1'b1, 8'h48}));
    chk("lat_hi",   wr[base].hi, 4);
    chk("lat_busy", int'(bus.busy), 0);

    base = nw;
    push(8'h58);
    push(8'h0D);
    push(8'h59);
    wait_idle();
    chk("cr_nw", nw - base, 3);
    chk("cr_w0", int'({wr[base].rs, wr[base].d}),     int'({1'b1, 8'h58}));
    chk("cr_w1", int'({wr[base+1].rs, wr[base+1].d}), int'({1'b0, 8'h80}));
    chk("cr_w2", int'({wr[base+2].rs, wr[base+2].d}), int'({1'b1, 8'h59}));

    base = nw;
    push(8'h0C);
    push(8'h5A);
    wait_idle();
    chk("ff_nw", nw - base, 2);
`ifdef LCD_CLEAR_ON_FF_EN
    chk("ff_w0",  int'({wr[base].rs, wr[base].d}), int'({1'b0, 8'h01}));
    chk("ff_gap", wr[base+1].rise - wr[base].rise, 18);
`else
    chk("ff_w0",  int'({wr[base].rs, wr[base].d}), int'({1'b1, 8'h0C}));
    chk("ff_gap", wr[base+1].rise - wr[base].rise, 10);
`endif
    chk("ff_w1", int'({wr[base+1].rs, wr[base+1].d}), int'({1'b1, 8'h5A}));

    // Reset in cycle 2 of a data write.
    base = nw;
    push(8'h61);
    k = 0;
    while (nw <= base && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mid_start", int'(nw > base), 1);
    k = 0;
    while (cyc < wr[base].rise + 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("mid_e",     int'(bus.lcd_e), 0);
    chk("mid_rs",    int'(bus.lcd_rs), 0);
    chk("mid_data",  int'(bus.lcd_data), 0);
    chk("mid_done",  int'(bus.init_done), 0);
    chk("mid_busy",  int'(bus.busy), 0);
    chk("mid_level", int'(bus.fifo_level), 0);
    chk("mid_drop",  int'(bus.drop_cnt), 0);
    rst = 1'b1;
    base = nw;
    k = 0;
    while (nw <= base && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("re_nw", int'(nw > base), 1);
    chk("re_w0", int'({wr[base].rs, wr[base].d}), int'({1'b0, 8'h38}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
